// File: rtl/gp_cmd_queue_if.sv
// rtl/gp_cmd_queue_if.sv - decoded slave-port bundle between the bus decoder and gp_cmd_queue
// master drives the transfer, slave (the queue) returns ready and read data.
interface gp_cmd_queue_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  cmd_en;
   logic                  slv_o_valid;
   logic [ADDR_WIDTH-1:0] slv_o_addr;
   logic [DATA_WIDTH-1:0] slv_o_wr_data;
   logic                  slv_o_rd0_wr1;
   logic                  slv_i_ready;
   logic [DATA_WIDTH-1:0] slv_i_rd_data;
   logic                  slv_i_rd_valid;

   modport master (
      output cmd_en, slv_o_valid, slv_o_addr, slv_o_wr_data, slv_o_rd0_wr1,
      input  slv_i_ready, slv_i_rd_data, slv_i_rd_valid
   );

   modport slave (
      input  cmd_en, slv_o_valid, slv_o_addr, slv_o_wr_data, slv_o_rd0_wr1,
      output slv_i_ready, slv_i_rd_data, slv_i_rd_valid
   );
endinterface

// File: rtl/gp_cmd_queue.sv
// rtl/gp_cmd_queue.sv - GP engine command store: word assembly, sequencing checks, FSM and debug read-back
// Optional per-entry even parity is enabled by defining GP_CMDQ_PARITY_EN.
module gp_cmd_queue #(
   parameter int          CMD_WIDTH  = 64,
   parameter int          CMD_DEPTH  = 128,
   parameter int          ADDR_WIDTH = 32,
   parameter int          DATA_WIDTH = 32,
   parameter int unsigned DBG_BASE   = 'h100,
   localparam int         IDX_W      = $clog2(CMD_DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cmd_rd_en,
   input  logic [IDX_W-1:0]     cmd_addr,
   output logic                 cmd_rd_valid,
   output logic                 cmd_rd_err,
   output logic [CMD_WIDTH-1:0] cmd_out,
   output logic [IDX_W:0]       cmd_count,
   output logic                 cmd_list_ready,
   input  logic                 cmd_exec_busy,
   gp_cmd_queue_if.slave        slv
);
   localparam int WORDS = CMD_WIDTH / DATA_WIDTH;
   localparam int WI_W  = $clog2(WORDS);
   localparam int DW    = DATA_WIDTH;

   typedef enum logic [1:0] {S_EMPTY, S_FILL, S_READY, S_ERR} state_t;

   state_t               state, state_nxt;
   logic [CMD_WIDTH-1:0] mem [CMD_DEPTH];
   logic [DW-1:0]        wbuf [WORDS];
   logic [WI_W-1:0]      word_idx;
   logic [IDX_W:0]       count;
   logic                 last_rwm, wr_rej, par_err;
   logic                 seq_err, fill_open, wr_rej_set;

   logic accept, is_wr, is_rd, hit_data, hit_ctrl, do_clear, do_commit;
   logic data_in, full, overflow, complete, type_bad, commit_bad;
   logic [1:0] wtype;
   logic [CMD_WIDTH-1:0] new_entry, rd_entry;
   logic rd_ok_base, rd_ok, par_bad, par_hit;
   logic [ADDR_WIDTH-1:0] dbg_k, dbg_entry;
   logic [WI_W-1:0] dbg_word;
   logic [DW-1:0] status, rd_mux;

   always_comb begin
      accept     = slv.cmd_en & slv.slv_o_valid & slv.slv_i_ready;
      is_wr      = accept & slv.slv_o_rd0_wr1;
      is_rd      = accept & ~slv.slv_o_rd0_wr1;
      hit_data   = is_wr && (slv.slv_o_addr == ADDR_WIDTH'(0));
      hit_ctrl   = is_wr && (slv.slv_o_addr == ADDR_WIDTH'(4));
      do_clear   = hit_ctrl & slv.slv_o_wr_data[1];
      do_commit  = hit_ctrl & slv.slv_o_wr_data[0] & ~slv.slv_o_wr_data[1];
      data_in    = hit_data & fill_open;
      full       = (count == (IDX_W+1)'(CMD_DEPTH));
      overflow   = data_in & full;
      complete   = data_in & ~full & (word_idx == WI_W'(WORDS-1));
      wtype      = slv.slv_o_wr_data[1:0];
      // An RWM must be immediately followed by a plain WRITE.
      type_bad   = wtype[1] | (last_rwm & (wtype != 2'b00));
      commit_bad = (word_idx != '0) || (count == '0) || last_rwm;
   end

   always_comb begin
      new_entry = '0;
      for (int i = 0; i < WORDS-1; i++)
         new_entry[i*DW +: DW] = wbuf[i];
      new_entry[(WORDS-1)*DW +: DW] = slv.slv_o_wr_data;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_EMPTY;
      else        state <= state_nxt;
   end

   // Next-state logic; clear wins over everything, including a commit in the same write
   always_comb begin
      state_nxt = state;
      if (do_clear) begin
         state_nxt = S_EMPTY;
      end else begin
         case (state)
            S_EMPTY, S_FILL: begin
               if (overflow || (complete && type_bad)) state_nxt = S_ERR;
               else if (do_commit) state_nxt = commit_bad ? S_ERR : S_READY;
               else if (data_in)   state_nxt = S_FILL;
            end
            default: state_nxt = state;
         endcase
      end
   end

   // Output decode
   always_comb begin
      cmd_list_ready = (state == S_READY);
      seq_err        = (state == S_ERR);
      fill_open      = (state == S_EMPTY) || (state == S_FILL);
      wr_rej_set     = hit_data & (state == S_READY);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || do_clear) begin
         count    <= '0;
         word_idx <= '0;
         last_rwm <= 1'b0;
         wr_rej   <= 1'b0;
         par_err  <= 1'b0;
      end else begin
         if (wr_rej_set) wr_rej <= 1'b1;
         if (par_hit)    par_err <= 1'b1;
         if (complete) begin
            word_idx <= '0;
            count    <= count + (IDX_W+1)'(1);
            last_rwm <= (wtype == 2'b01);
         end else if (data_in && !full) begin
            word_idx <= word_idx + WI_W'(1);
         end
      end
   end

   // Storage is intentionally not reset; count qualifies every read.
   always_ff @(posedge clk) begin
      if (data_in && !full) wbuf[word_idx] <= slv.slv_o_wr_data;
      if (complete)         mem[count[IDX_W-1:0]] <= new_entry;
   end

`ifdef GP_CMDQ_PARITY_EN
   logic par_mem [CMD_DEPTH];
   always_ff @(posedge clk) begin
      if (complete) par_mem[count[IDX_W-1:0]] <= ^new_entry;
   end
   assign par_bad = (^rd_entry) != par_mem[cmd_addr];
`else
   assign par_bad = 1'b0;
`endif

   always_comb begin
      rd_entry   = mem[cmd_addr];
      rd_ok_base = (state == S_READY) && ({1'b0, cmd_addr} < count);
      rd_ok      = rd_ok_base & ~par_bad;
      par_hit    = cmd_rd_en & rd_ok_base & par_bad;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_rd_valid <= 1'b0;
         cmd_rd_err   <= 1'b0;
         cmd_out      <= '0;
      end else begin
         cmd_rd_valid <= cmd_rd_en;
         cmd_rd_err   <= cmd_rd_en & ~rd_ok;
         cmd_out      <= (cmd_rd_en && rd_ok) ? rd_entry : '0;
      end
   end

   // Debug window: one bus word per DW-bit slice, entries laid out back to back.
   always_comb begin
      dbg_k     = (slv.slv_o_addr - ADDR_WIDTH'(DBG_BASE)) >> 2;
      dbg_entry = dbg_k >> WI_W;
      dbg_word  = dbg_k[WI_W-1:0];
      status    = '0;
      status[16 +: IDX_W+1] = count;
      status[3:0] = {par_err, wr_rej, seq_err, cmd_list_ready};
      rd_mux    = '0;
      if (slv.slv_o_addr == ADDR_WIDTH'(8))
         rd_mux = status;
      else if ((slv.slv_o_addr >= ADDR_WIDTH'(DBG_BASE)) && (dbg_entry < ADDR_WIDTH'(count)))
         rd_mux = mem[dbg_entry[IDX_W-1:0]][int'(dbg_word)*DW +: DW];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slv.slv_i_ready    <= 1'b1;
         slv.slv_i_rd_valid <= 1'b0;
         slv.slv_i_rd_data  <= '0;
      end else begin
         slv.slv_i_ready    <= ~cmd_exec_busy;
         slv.slv_i_rd_valid <= is_rd;
         slv.slv_i_rd_data  <= is_rd ? rd_mux : '0;
      end
   end

   assign cmd_count = count;
endmodule

// File: tb/tb_gp_cmd_queue.sv
// tb/tb_gp_cmd_queue.sv - directed self-checking bench for gp_cmd_queue
// Parity scenario is included when GP_CMDQ_PARITY_EN is defined.
module tb_gp_cmd_queue;
   localparam logic [31:0] DBG = 32'h100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_rd_en = 1'b0;
   logic [6:0]  cmd_addr = '0;
   logic        cmd_rd_valid, cmd_rd_err, cmd_list_ready;
   logic [63:0] cmd_out;
   logic [7:0]  cmd_count;
   logic        cmd_exec_busy = 1'b0;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] rd;
   logic        rv;
   logic [63:0] fo;
   logic        fe, fv;

   gp_cmd_queue_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

   gp_cmd_queue #(
      .CMD_WIDTH(64), .CMD_DEPTH(128), .ADDR_WIDTH(32), .DATA_WIDTH(32), .DBG_BASE('h100)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_rd_en(cmd_rd_en), .cmd_addr(cmd_addr),
      .cmd_rd_valid(cmd_rd_valid), .cmd_rd_err(cmd_rd_err), .cmd_out(cmd_out),
      .cmd_count(cmd_count), .cmd_list_ready(cmd_list_ready),
      .cmd_exec_busy(cmd_exec_busy),
      .slv(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic slv_wr(input logic [31:0] a, input logic [31:0] d);
      bus.cmd_en = 1'b1; bus.slv_o_valid = 1'b1; bus.slv_o_rd0_wr1 = 1'b1;
      bus.slv_o_addr = a; bus.slv_o_wr_data = d;
      @(posedge clk); #1;
      bus.cmd_en = 1'b0; bus.slv_o_valid = 1'b0;
   endtask

   task automatic slv_rd(input logic [31:0] a, output logic [31:0] d, output logic v);
      bus.cmd_en = 1'b1; bus.slv_o_valid = 1'b1; bus.slv_o_rd0_wr1 = 1'b0;
      bus.slv_o_addr = a;
      @(posedge clk); #1;
      bus.cmd_en = 1'b0; bus.slv_o_valid = 1'b0;
      d = bus.slv_i_rd_data; v = bus.slv_i_rd_valid;
   endtask

   task automatic chk_status(input string tag, input logic [31:0] exp);
      logic [31:0] d;
      logic        v;
      slv_rd(32'h8, d, v);
      chk({tag, "_v"}, {63'd0, v}, 64'd1);
      chk(tag, {32'd0, d}, {32'd0, exp});
   endtask

   task automatic fsm_rd(input logic [6:0] idx, output logic [63:0] o, output logic e, output logic v);
      cmd_rd_en = 1'b1; cmd_addr = idx;
      @(posedge clk); #1;
      cmd_rd_en = 1'b0;
      o = cmd_out; e = cmd_rd_err; v = cmd_rd_valid;
   endtask

   task automatic push(input logic [31:0] lo, input logic [31:0] hi);
      slv_wr(32'h0, lo);
      slv_wr(32'h0, hi);
   endtask

   initial begin
      bus.cmd_en = 1'b0; bus.slv_o_valid = 1'b0; bus.slv_o_rd0_wr1 = 1'b0;
      bus.slv_o_addr = '0; bus.slv_o_wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", {56'd0, cmd_count}, 64'd0);
      chk("rst_ready", {63'd0, cmd_list_ready}, 64'd0);
      chk("rst_slv_ready", {63'd0, bus.slv_i_ready}, 64'd1);
      chk("rst_rd_valid", {63'd0, cmd_rd_valid}, 64'd0);
      chk("rst_cmd_out", cmd_out, 64'd0);
      rst_n = 1'b1;

      // single WRITE command, commit, reads
      push(32'hDEAD_0000, 32'h1000_0000);
      slv_wr(32'h4, 32'h1);
      chk("c1_count", {56'd0, cmd_count}, 64'd1);
      chk("c1_ready", {63'd0, cmd_list_ready}, 64'd1);
      chk_status("c1_status", 32'h0001_0001);
      fsm_rd(7'd0, fo, fe, fv);
      chk("c1_fsm_v", {63'd0, fv}, 64'd1);
      chk("c1_fsm_err", {63'd0, fe}, 64'd0);
      chk("c1_fsm_out", fo, 64'h1000_0000_DEAD_0000);
      fsm_rd(7'd1, fo, fe, fv);
      chk("c1_oob_err", {63'd0, fe}, 64'd1);
      chk("c1_oob_out", fo, 64'd0);
      slv_rd(DBG + 32'h4, rd, rv);
      chk("dbg_hi", {32'd0, rd}, 64'h1000_0000);
      slv_rd(DBG, rd, rv);
      chk("dbg_lo", {32'd0, rd}, 64'hDEAD_0000);
      slv_rd(DBG + 32'h8, rd, rv);
      chk("dbg_past_count", {32'd0, rd}, 64'd0);
      slv_rd(32'h40, rd, rv);
      chk("unmapped_v", {63'd0, rv}, 64'd1);
      chk("unmapped_d", {32'd0, rd}, 64'd0);

      // READY drops data, second commit is a no-op
      slv_wr(32'h0, 32'h1234_5678);
      slv_wr(32'h4, 32'h1);
      chk_status("wr_rej_status", 32'h0001_0005);

      // FSM read concurrent with clear sees the pre-clear list
      cmd_rd_en = 1'b1; cmd_addr = 7'd0;
      slv_wr(32'h4, 32'h2);
      cmd_rd_en = 1'b0;
      chk("concur_err", {63'd0, cmd_rd_err}, 64'd0);
      chk("concur_out", cmd_out, 64'h1000_0000_DEAD_0000);
      chk_status("clear_status", 32'h0);

      // clear beats commit
      slv_wr(32'h4, 32'h3);
      chk_status("clr_commit", 32'h0);

      // RWM followed by WRITE
      push(32'hAAAA_0000, 32'h2000_0001);
      push(32'hBBBB_0000, 32'h3000_0000);
      slv_wr(32'h4, 32'h1);
      chk_status("rwm_ok", 32'h0002_0001);
      fsm_rd(7'd1, fo, fe, fv);
      chk("rwm_e1", fo, 64'h3000_0000_BBBB_0000);
      fsm_rd(7'd2, fo, fe, fv);
      chk("idx_eq_count_err", {63'd0, fe}, 64'd1);
      fsm_rd(7'd5, fo, fe, fv);
      chk("idx5_err", {63'd0, fe}, 64'd1);
      chk("idx5_out", fo, 64'd0);

      // RWM followed by RWM
      slv_wr(32'h4, 32'h2);
      push(32'h1, 32'h2000_0001);
      push(32'h2, 32'h2000_0001);
      chk_status("rwm_rwm", 32'h0002_0002);
      fsm_rd(7'd0, fo, fe, fv);
      chk("err_fsm_err", {63'd0, fe}, 64'd1);
      chk("err_fsm_out", fo, 64'd0);

      // reserved type
      slv_wr(32'h4, 32'h2);
      push(32'h5, 32'h0000_0002);
      chk_status("reserved", 32'h0001_0002);

      // bad commits
      slv_wr(32'h4, 32'h2);
      slv_wr(32'h0, 32'h7);
      slv_wr(32'h4, 32'h1);
      chk_status("commit_partial", 32'h0000_0002);
      slv_wr(32'h4, 32'h2);
      push(32'h0, 32'h2000_0001);
      slv_wr(32'h4, 32'h1);
      chk_status("commit_last_rwm", 32'h0001_0002);
      slv_wr(32'h4, 32'h2);
      slv_wr(32'h4, 32'h1);
      chk_status("commit_empty", 32'h0000_0002);

      // busy stalls the slave port
      slv_wr(32'h4, 32'h2);
      cmd_exec_busy = 1'b1;
      @(posedge clk); #1;
      chk("busy_ready", {63'd0, bus.slv_i_ready}, 64'd0);
      push(32'h9, 32'h0);
      slv_rd(32'h8, rd, rv);
      chk("busy_rd_v", {63'd0, rv}, 64'd0);
      cmd_exec_busy = 1'b0;
      @(posedge clk); #1;
      chk("unbusy_ready", {63'd0, bus.slv_i_ready}, 64'd1);
      chk_status("busy_no_write", 32'h0);

      // fill to depth, then overflow
      for (int i = 0; i < 128; i++) push(i, i << 4);
      chk_status("full", 32'h0080_0000);
      slv_rd(DBG + 32'h3FC, rd, rv);
      chk("dbg_e127_hi", {32'd0, rd}, 64'h7F0);
      slv_rd(DBG + 32'h3F8, rd, rv);
      chk("dbg_e127_lo", {32'd0, rd}, 64'h7F);
      slv_wr(32'h0, 32'h1);
      chk_status("overflow", 32'h0080_0002);
      slv_wr(32'h4, 32'h2);
      chk_status("ovf_clear", 32'h0);
      chk("ovf_clear_count", {56'd0, cmd_count}, 64'd0);

      // reset mid-assembly discards the partial word
      slv_wr(32'h0, 32'h1111_1111);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("midrst_count", {56'd0, cmd_count}, 64'd0);
      push(32'h2222_2222, 32'h3000_0000);
      slv_wr(32'h4, 32'h1);
      chk_status("midrst_status", 32'h0001_0001);
      fsm_rd(7'd0, fo, fe, fv);
      chk("midrst_entry", fo, 64'h3000_0000_2222_2222);

`ifdef GP_CMDQ_PARITY_EN
      dut.mem[0] = dut.mem[0] ^ 64'h1;
      fsm_rd(7'd0, fo, fe, fv);
      chk("par_err", {63'd0, fe}, 64'd1);
      chk("par_out", fo, 64'd0);
      chk_status("par_status", 32'h0001_0009);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
